// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester (CPU, DMA) arbiter in front of a single memory port.
// One transaction is in flight at a time. A grant takes one IDLE cycle.
// The owner's request is then forwarded combinationally to memory until
// mem_ready completes it. If mem_ready does not arrive in time, a timeout
// aborts the transaction with an error pulse.
//
// Handshake: a requester raises *_valid with a stable payload (addr, wdata,
// wstrb) and holds it until its *_ready pulses for exactly one cycle.
// *_rdata is meaningful only while the matching *_ready is high and is zero
// otherwise. On the memory side, mem_valid is high in every BUSY cycle, and
// the cycle with mem_ready=1 completes the access. The arbiter never latches
// the payload, so requesters must keep it stable until their ready.
//
// Parameters
//   ROUND_ROBIN  1: on contention grant the requester not granted last
//                0: on contention the CPU always wins
//   TIMEOUT      busy cycles without mem_ready before abort (1..65535)
//   ERR_DATA     read data returned on a timeout abort
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cpu_*/dma_* valid,addr,wdata,wstrb   requester inputs
//   cpu_*/dma_* ready,rdata     completion pulse and read data
//   mem_valid,addr,wdata,wstrb  shared memory request
//   mem_ready, mem_rdata        memory completion and read data
//   owner                       FSM state: 00 idle, 01 CPU, 10 DMA
//   timeout_err                 one-cycle pulse on a timeout abort
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          ROUND_ROBIN = 1,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        dma_valid,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_wstrb,
    output logic        dma_ready,
    output logic [31:0] dma_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    // The encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CPU_BUSY = 2'b01,
        DMA_BUSY = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_dma_q, last_dma_d;   // 1: DMA was granted last
    logic [15:0] busy_cnt_q, busy_cnt_d;

    logic        busy;
    logic        done;
    logic        abort;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        grant_dma;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dma_q <= 1'b1;            // CPU wins the first contention
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dma_q <= last_dma_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_dma_d  = last_dma_q;
        busy_cnt_d  = busy_cnt_q;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        dma_ready   = 1'b0;
        dma_rdata   = '0;
        timeout_err = 1'b0;
        grant_dma   = 1'b0;

        busy  = (state_q != IDLE);
        // mem_ready wins over the abort when both land in the same cycle.
        done  = busy && mem_ready;
        abort = busy && !mem_ready && (busy_cnt_q == TIMEOUT_CNT);
        // A transaction caught by reset is abandoned without a ready pulse.
        rsp_valid = (done || abort) && !reset;
        rsp_data  = done ? mem_rdata : ERR_DATA;

        case (state_q)
            IDLE: begin
                if (cpu_valid || dma_valid) begin
                    if (cpu_valid && dma_valid)
                        grant_dma = (ROUND_ROBIN != 0) && !last_dma_q;
                    else
                        grant_dma = dma_valid;
                    state_d    = grant_dma ? DMA_BUSY : CPU_BUSY;
                    last_dma_d = grant_dma;
                    busy_cnt_d = '0;
                end
            end
            CPU_BUSY: begin
                mem_valid = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wstrb;
                cpu_ready = rsp_valid;
                cpu_rdata = rsp_valid ? rsp_data : '0;
            end
            DMA_BUSY: begin
                mem_valid = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_wstrb = dma_wstrb;
                dma_ready = rsp_valid;
                dma_rdata = rsp_valid ? rsp_data : '0;
            end
            default: state_d = IDLE;
        endcase

        if (busy) begin
            timeout_err = abort && !reset;
            if (done || abort)
                state_d = IDLE;
            else
                busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    assign owner = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters share every input: dut 0 is round robin, dut 1 is CPU fixed
// priority, both with TIMEOUT=4. Directed tasks check the named scenarios
// against constants. The random task checks every output of both DUTs each
// cycle against a transaction-level reference model. Inputs change 1 ns
// after the rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, dma_valid, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [3:0]  cpu_wstrb, dma_wstrb;

    logic        o_cpu_ready[2], o_dma_ready[2], o_mem_valid[2], o_terr[2];
    logic [31:0] o_cpu_rdata[2], o_dma_rdata[2], o_mem_addr[2], o_mem_wdata[2];
    logic [3:0]  o_mem_wstrb[2];
    logic [1:0]  o_owner[2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(o_cpu_ready[0]), .cpu_rdata(o_cpu_rdata[0]),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
        .dma_ready(o_dma_ready[0]), .dma_rdata(o_dma_rdata[0]),
        .mem_valid(o_mem_valid[0]), .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]),
        .mem_wstrb(o_mem_wstrb[0]), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(o_owner[0]), .timeout_err(o_terr[0])
    );

    mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(o_cpu_ready[1]), .cpu_rdata(o_cpu_rdata[1]),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
        .dma_ready(o_dma_ready[1]), .dma_rdata(o_dma_rdata[1]),
        .mem_valid(o_mem_valid[1]), .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]),
        .mem_wstrb(o_mem_wstrb[1]), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(o_owner[1]), .timeout_err(o_terr[1])
    );

    // ---------------- reference model ----------------
    // who: 0 nobody, 1 CPU, 2 DMA; waited: busy cycles seen without mem_ready.
    int m_who[2], m_waited[2], m_last[2];

    logic        e_cpu_ready[2], e_dma_ready[2], e_mem_valid[2], e_terr[2];
    logic [31:0] e_cpu_rdata[2], e_dma_rdata[2], e_mem_addr[2], e_mem_wdata[2];
    logic [3:0]  e_mem_wstrb[2];
    logic [1:0]  e_owner[2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic        fin;
            logic [31:0] rsp;
            e_owner[i]     = 2'(m_who[i]);
            e_mem_valid[i] = (m_who[i] != 0);
            e_mem_addr[i]  = (m_who[i] == 1) ? cpu_addr  : (m_who[i] == 2) ? dma_addr  : 32'h0;
            e_mem_wdata[i] = (m_who[i] == 1) ? cpu_wdata : (m_who[i] == 2) ? dma_wdata : 32'h0;
            e_mem_wstrb[i] = (m_who[i] == 1) ? cpu_wstrb : (m_who[i] == 2) ? dma_wstrb : 4'h0;
            fin = (m_who[i] != 0) && !reset && (mem_ready || m_waited[i] == TO);
            rsp = mem_ready ? mem_rdata : ERR;
            e_cpu_ready[i] = fin && (m_who[i] == 1);
            e_dma_ready[i] = fin && (m_who[i] == 2);
            e_cpu_rdata[i] = e_cpu_ready[i] ? rsp : 32'h0;
            e_dma_rdata[i] = e_dma_ready[i] ? rsp : 32'h0;
            e_terr[i]      = fin && !mem_ready;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_who[i] <= 0; m_waited[i] <= 0; m_last[i] <= 2;
            end else if (m_who[i] != 0) begin
                if (mem_ready || m_waited[i] == TO) m_who[i] <= 0;
                else m_waited[i] <= m_waited[i] + 1;
            end else begin
                int pick;
                pick = 0;
                if (cpu_valid && dma_valid) pick = (i == 0 && m_last[i] == 1) ? 2 : 1;
                else if (cpu_valid) pick = 1;
                else if (dma_valid) pick = 2;
                if (pick != 0) begin
                    m_who[i] <= pick; m_last[i] <= pick; m_waited[i] <= 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        dma_valid = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cpu_valid = 1'b1;
        dma_valid = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b00 || o_mem_valid[i] !== 1'b0 || o_cpu_ready[i] !== 1'b0 ||
                o_dma_ready[i] !== 1'b0 || o_terr[i] !== 1'b0 || o_cpu_rdata[i] !== 32'h0 ||
                o_dma_rdata[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset dut%0d: owner=%b mem_valid=%b rdy=%b%b terr=%b rdata=%h/%h, want all zero",
                         i, o_owner[i], o_mem_valid[i], o_cpu_ready[i], o_dma_ready[i], o_terr[i],
                         o_cpu_rdata[i], o_dma_rdata[i]);
            end
        end
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 32'h100; cpu_wstrb = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b00 || o_cpu_ready[i] !== 1'b0) begin
                n_err++;
                $display("FAIL cpu_read_grant dut%0d: owner=%b cpu_ready=%b, want 00/0", i, o_owner[i], o_cpu_ready[i]);
            end
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b01 || o_mem_valid[i] !== 1'b1 || o_mem_addr[i] !== 32'h100 ||
                o_cpu_ready[i] !== 1'b1 || o_cpu_rdata[i] !== 32'h1234 || o_dma_ready[i] !== 1'b0) begin
                n_err++;
                $display("FAIL cpu_read_done dut%0d: owner=%b mv=%b addr=%h rdy=%b rdata=%h, want 01/1/100/1/1234",
                         i, o_owner[i], o_mem_valid[i], o_mem_addr[i], o_cpu_ready[i], o_cpu_rdata[i]);
            end
        end
        tick();
        cpu_valid = 1'b0; mem_ready = 1'b1;   // mem_ready must be ignored in IDLE
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b00 || o_cpu_ready[i] !== 1'b0 || o_mem_valid[i] !== 1'b0 ||
                o_mem_addr[i] !== 32'h0) begin
                n_err++;
                $display("FAIL cpu_read_idle dut%0d: owner=%b rdy=%b mv=%b addr=%h, want 00/0/0/0",
                         i, o_owner[i], o_cpu_ready[i], o_mem_valid[i], o_mem_addr[i]);
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 32'hA0; dma_valid = 1'b1; dma_addr = 32'hB0;
        mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [1:0] want_rr, want_fp;
            mem_rdata = $urandom;
            want_rr = (k % 4 == 1) ? 2'b01 : (k % 4 == 3) ? 2'b10 : 2'b00;
            want_fp = (k % 2 == 1) ? 2'b01 : 2'b00;
            @(negedge clk);
            n_vec++;
            if (o_owner[0] !== want_rr || o_cpu_ready[0] !== (k % 4 == 1) || o_dma_ready[0] !== (k % 4 == 3)) begin
                n_err++;
                $display("FAIL round_robin k=%0d: owner=%b rdy=%b%b, want owner=%b", k, o_owner[0],
                         o_cpu_ready[0], o_dma_ready[0], want_rr);
            end
            n_vec++;
            if (o_owner[1] !== want_fp || o_cpu_ready[1] !== (k % 2 == 1) || o_dma_ready[1] !== 1'b0) begin
                n_err++;
                $display("FAIL fixed_prio k=%0d: owner=%b rdy=%b%b, want owner=%b, no dma_ready", k, o_owner[1],
                         o_cpu_ready[1], o_dma_ready[1], want_fp);
            end
            if (k % 4 == 3) begin
                n_vec++;
                if (o_dma_rdata[0] !== mem_rdata || o_mem_addr[0] !== 32'hB0) begin
                    n_err++;
                    $display("FAIL rr_dma_data k=%0d: rdata=%h addr=%h, want %h/b0", k, o_dma_rdata[0],
                             o_mem_addr[0], mem_rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    // race=1: mem_ready arrives exactly in the cycle the counter hits TIMEOUT.
    task automatic test_timeout(input bit race);
        logic [31:0] rd;
        rd = $urandom;
        do_reset();
        dma_valid = 1'b1; dma_addr = $urandom; dma_wdata = $urandom; dma_wstrb = 4'b0011;
        tick();   // grant cycle
        for (int k = 1; k <= TO + 1; k++) begin
            bit last;
            last = (k == TO + 1);
            mem_ready = race && last;
            mem_rdata = rd;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_owner[i] !== 2'b10 || o_mem_valid[i] !== 1'b1 || o_mem_wstrb[i] !== 4'b0011 ||
                    o_mem_wdata[i] !== dma_wdata || o_dma_ready[i] !== last || o_terr[i] !== (last && !race) ||
                    o_dma_rdata[i] !== (!last ? 32'h0 : race ? rd : ERR)) begin
                    n_err++;
                    $display("FAIL timeout race=%0d dut%0d busy=%0d: owner=%b wstrb=%b rdy=%b terr=%b rdata=%h",
                             race, i, k, o_owner[i], o_mem_wstrb[i], o_dma_ready[i], o_terr[i], o_dma_rdata[i]);
                end
            end
            tick();
        end
        dma_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b00 || o_terr[i] !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_idle race=%0d dut%0d: owner=%b terr=%b, want 00/0", race, i, o_owner[i], o_terr[i]);
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cpu_valid = 1'b1; cpu_addr = 32'h200;
        tick();   // grant
        tick();   // first busy cycle, no mem_ready
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_cpu_ready[i] !== 1'b0 || o_owner[i] !== 2'b01) begin
                n_err++;
                $display("FAIL reset_mid_busy dut%0d: owner=%b cpu_ready=%b, want 01/0", i, o_owner[i], o_cpu_ready[i]);
            end
        end
        tick();
        reset = 1'b0; dma_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h55AA;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b00 || o_mem_valid[i] !== 1'b0 || o_cpu_ready[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_abandon dut%0d: owner=%b mv=%b cpu_ready=%b, want 00/0/0",
                         i, o_owner[i], o_mem_valid[i], o_cpu_ready[i]);
            end
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_owner[i] !== 2'b01 || o_cpu_ready[i] !== 1'b1 || o_cpu_rdata[i] !== 32'h55AA) begin
                n_err++;
                $display("FAIL reset_first_grant dut%0d: owner=%b rdy=%b rdata=%h, want 01/1/55aa",
                         i, o_owner[i], o_cpu_ready[i], o_cpu_rdata[i]);
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit cpu_done, dma_done;
            if (!cpu_valid && $urandom_range(0, 1) == 1) begin
                cpu_valid = 1'b1; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
            end
            if (!dma_valid && $urandom_range(0, 1) == 1) begin
                dma_valid = 1'b1; dma_addr = $urandom; dma_wdata = $urandom; dma_wstrb = 4'($urandom);
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_owner[i] !== e_owner[i] || o_mem_valid[i] !== e_mem_valid[i] ||
                    o_mem_addr[i] !== e_mem_addr[i] || o_mem_wdata[i] !== e_mem_wdata[i] ||
                    o_mem_wstrb[i] !== e_mem_wstrb[i]) begin
                    n_err++;
                    $display("FAIL random_req c=%0d dut%0d: owner=%b/%b mv=%b/%b addr=%h/%h wdata=%h/%h wstrb=%h/%h (got/want)",
                             c, i, o_owner[i], e_owner[i], o_mem_valid[i], e_mem_valid[i], o_mem_addr[i],
                             e_mem_addr[i], o_mem_wdata[i], e_mem_wdata[i], o_mem_wstrb[i], e_mem_wstrb[i]);
                end
                n_vec++;
                if (o_cpu_ready[i] !== e_cpu_ready[i] || o_dma_ready[i] !== e_dma_ready[i] ||
                    o_cpu_rdata[i] !== e_cpu_rdata[i] || o_dma_rdata[i] !== e_dma_rdata[i] ||
                    o_terr[i] !== e_terr[i]) begin
                    n_err++;
                    $display("FAIL random_rsp c=%0d dut%0d: rdy=%b%b/%b%b rdata=%h,%h/%h,%h terr=%b/%b (got/want)",
                             c, i, o_cpu_ready[i], o_dma_ready[i], e_cpu_ready[i], e_dma_ready[i],
                             o_cpu_rdata[i], o_dma_rdata[i], e_cpu_rdata[i], e_dma_rdata[i], o_terr[i], e_terr[i]);
                end
            end
            cpu_done = e_cpu_ready[0];
            dma_done = e_dma_ready[0];
            tick();
            // Completed requesters usually drop valid; sometimes they re-request at once.
            if (cpu_done) begin
                cpu_valid = ($urandom_range(0, 3) == 0);
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
            end
            if (dma_done) begin
                dma_valid = ($urandom_range(0, 3) == 0);
                dma_addr = $urandom; dma_wdata = $urandom; dma_wstrb = 4'($urandom);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_contention();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
